// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host transmitter.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        ACK,
        WAIT_REL
    } ps2_state_t;

    localparam int unsigned PS2_FRAME_BITS = 10;
    localparam int unsigned PS2_FILTER_LEN = 8;

    function automatic int unsigned us_to_cycles(input int unsigned freq_hz,
                                                 input int unsigned us);
        return (freq_hz / 1_000_000) * us;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 pin synchroniser with optional 8-sample glitch filter and falling-edge strobe.
module ps2_line_sync
    import ps2_pkg::*;
#(
    parameter bit FILTER_EN = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_line,
    output logic o_level,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic w_level;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_line;
            r_sync <= r_meta;
            r_prev <= w_level;
        end
    end

    generate
        if (FILTER_EN) begin : g_filt
            logic       r_filt;
            logic [2:0] r_cnt;

            // Level flips only after PS2_FILTER_LEN consecutive disagreeing samples.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_filt <= 1'b1;
                    r_cnt  <= '0;
                end else if (r_sync == r_filt) begin
                    r_cnt <= '0;
                end else if (r_cnt == 3'(PS2_FILTER_LEN - 1)) begin
                    r_filt <= r_sync;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 3'd1;
                end
            end

            assign w_level = r_filt;
        end else begin : g_nofilt
            assign w_level = r_sync;
        end
    endgenerate

    assign o_level = w_level;
    assign o_fall  = r_prev && !w_level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (inhibit, RTS, device-clocked shift, ack, timeout).
// Define PS2_TX_FILTER_EN to glitch-filter the PS/2 clock before edge detection.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned FREQ_HZ    = 25_000_000,
    parameter int unsigned INHIBIT_US = 120,
    parameter int unsigned TIMEOUT_US = 15000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       done_o,
    output logic       err_o,
    output logic       tx_active_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o
);

    localparam int unsigned INH_CYC = us_to_cycles(FREQ_HZ, INHIBIT_US);
    localparam int unsigned TO_CYC  = us_to_cycles(FREQ_HZ, TIMEOUT_US);
    localparam int unsigned INH_W   = $clog2(INH_CYC + 1);
    localparam int unsigned TO_W    = $clog2(TO_CYC + 1);
    localparam int unsigned IDX_W   = $clog2(PS2_FRAME_BITS);

`ifdef PS2_TX_FILTER_EN
    localparam bit CLK_FILTER = 1'b1;
`else
    localparam bit CLK_FILTER = 1'b0;
`endif

    ps2_state_t r_state, w_next;

    logic                      w_clk_lvl, w_clk_fall;
    logic                      w_data_lvl, w_data_fall_unused;
    logic [PS2_FRAME_BITS-1:0] r_shreg;
    logic [IDX_W-1:0]          r_bit_idx;
    logic [INH_W-1:0]          r_inh_cnt;
    logic [TO_W-1:0]           r_to_cnt;
    logic                      r_clk_oe, r_data_oe, r_done, r_err;
    logic                      w_accept, w_inh_last, w_timeout, w_done, w_err;

    ps2_line_sync #(.FILTER_EN(CLK_FILTER)) u_clk_sync (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_line  (ps2_clk_i),
        .o_level (w_clk_lvl),
        .o_fall  (w_clk_fall)
    );

    ps2_line_sync #(.FILTER_EN(1'b0)) u_data_sync (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_line  (ps2_data_i),
        .o_level (w_data_lvl),
        .o_fall  (w_data_fall_unused)
    );

    assign ready_o       = (r_state == IDLE) && !r_done && !r_err;
    assign tx_active_o   = (r_state != IDLE);
    assign done_o        = r_done;
    assign err_o         = r_err;
    assign ps2_clk_oe_o  = r_clk_oe;
    assign ps2_data_oe_o = r_data_oe;
    assign w_accept      = valid_i && ready_o;
    assign w_inh_last    = (r_inh_cnt == INH_W'(INH_CYC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_done    = 1'b0;
        w_err     = 1'b0;
        w_timeout = (r_state inside {RTS, SHIFT, ACK, WAIT_REL}) &&
                    (r_to_cnt == TO_W'(TO_CYC - 1));
        case (r_state)
            IDLE:     if (w_accept) w_next = INHIBIT;
            INHIBIT:  if (w_inh_last) w_next = RTS;
            RTS:      w_next = SHIFT;
            SHIFT:    if (w_clk_fall && r_bit_idx == IDX_W'(PS2_FRAME_BITS - 1)) w_next = ACK;
            ACK: begin
                if (w_clk_fall) begin
                    if (w_data_lvl) begin
                        w_err  = 1'b1;
                        w_next = IDLE;
                    end else begin
                        w_next = WAIT_REL;
                    end
                end
            end
            WAIT_REL: begin
                if (w_clk_lvl && w_data_lvl) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end
            end
            default:  w_next = IDLE;
        endcase
        // Timeout overrides any ack outcome decided in the same cycle.
        if (w_timeout) begin
            w_next = IDLE;
            w_done = 1'b0;
            w_err  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shreg   <= '0;
            r_bit_idx <= '0;
            r_inh_cnt <= '0;
            r_to_cnt  <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= w_done;
            r_err  <= w_err;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shreg   <= {1'b1, ~^data_i, data_i};
                        r_bit_idx <= '0;
                        r_inh_cnt <= '0;
                        r_clk_oe  <= 1'b1;
                        r_data_oe <= 1'b0;
                    end
                end
                INHIBIT: begin
                    r_inh_cnt <= r_inh_cnt + INH_W'(1);
                    if (r_inh_cnt == INH_W'(INH_CYC - 2)) r_data_oe <= 1'b1;
                    if (w_inh_last) begin
                        r_clk_oe <= 1'b0;
                        r_to_cnt <= '0;
                    end
                end
                default: begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                    if (r_state == SHIFT && w_clk_fall) begin
                        r_data_oe <= ~r_shreg[0];
                        r_shreg   <= {1'b0, r_shreg[PS2_FRAME_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + IDX_W'(1);
                    end
                end
            endcase
            // Every return to IDLE (done, nack, timeout) releases both lines.
            if (w_next == IDLE) begin
                r_clk_oe  <= 1'b0;
                r_data_oe <= 1'b0;
            end
        end
    end

endmodule
